mest_pro_result_buf: RTL and testbench

- Result collection buffer directly downstream of the processor core.
- Captures each executed result ({carry, zero, result}) on the core's valid-result strobe into a first-word-fall-through FIFO.
- Exposes the captured results to a host through a valid/ready read port.
- Tracks the run lifecycle from start, through the core's all-done, to drained, so the host knows when every result of a program has been consumed.

---
 rtl/mest_pro_result_buf.sv | 122 ++++++++++++
 tb/tb_mest_pro_result_buf.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mest_pro_result_buf.sv
// Result collection buffer behind the processor core: a FWFT FIFO of {carry, zero, result}
// with a run lifecycle (start -> collect -> drain -> done) for the host read side.
module mest_pro_result_buf #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     i_reset_n,
  input  logic                     i_start,
  input  logic                     i_valid_result,
  input  logic [DATA_W-1:0]        i_result,
  input  logic                     i_carry,
  input  logic                     i_zero_flag,
  input  logic                     i_all_done,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [DATA_W+1:0]        o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow,
  output logic [7:0]               o_total,
  output logic                     o_done
);

  // state   | meaning
  // IDLE    | waiting for the first run after reset
  // COLLECT | accepting core results
  // DRAIN   | core finished, host emptying the buffer
  // DONE    | run complete and buffer drained

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            overflow;
  logic [7:0]      total;
  logic [EW-1:0]   rd_data;
  logic [EW-1:0]   wr_entry;
  logic            pop, push_req, push_ok, drop, start_clr;

  always_comb begin
    wr_entry   = {i_carry, i_zero_flag, i_result};
    pop        = (count != '0) && i_rd_ready;
    push_req   = (state == S_COLLECT) && i_valid_result;
    // A full FIFO still takes a result when the host frees a slot in the same cycle.
    push_ok    = push_req && ((count != CW'(DEPTH)) || pop);
    drop       = push_req && !push_ok;
    start_clr  = i_start && ((state == S_IDLE) || (state == S_DONE));
    rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
    count_nxt  = count;
    if (push_ok && !pop)
      count_nxt = count + CW'(1);
    else if (!push_ok && pop)
      count_nxt = count - CW'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (i_start)          state_nxt = S_COLLECT;
      S_COLLECT: if (i_all_done)       state_nxt = S_DRAIN;
      S_DRAIN:   if (count_nxt == '0)  state_nxt = S_DONE;
      S_DONE:    if (i_start)          state_nxt = S_COLLECT;
      default:                         state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      total    <= '0;
      rd_data  <= '0;
    end else begin
      state <= state_nxt;
      if (start_clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
        total    <= '0;
      end else begin
        if (push_ok)
          wr_ptr <= wr_ptr + AW'(1);
        rd_ptr <= rd_ptr_nxt;
        count  <= count_nxt;
        if (drop)
          overflow <= 1'b1;
        if (push_ok && (total != 8'hFF))
          total <= total + 8'd1;
        // Head register: forward the entry being written when it becomes the new head.
        if (count_nxt != '0)
          rd_data <= (push_ok && (rd_ptr_nxt == wr_ptr)) ? wr_entry : mem[rd_ptr_nxt];
      end
    end
  end

  assign o_rd_valid = (count != '0);
  assign o_rd_data  = rd_data;
  assign o_count    = count;
  assign o_full     = (count == CW'(DEPTH));
  assign o_empty    = (count == '0);
  assign o_overflow = overflow;
  assign o_total    = total;
  assign o_done     = (state == S_DONE);

endmodule

// File: tb/tb_mest_pro_result_buf.sv
// Directed bench for mest_pro_result_buf: inputs driven and outputs sampled on the falling edge,
// expected entries tracked in a queue built from the stimulus.
module tb_mest_pro_result_buf;

  logic       clk;
  logic       i_reset_n;
  logic       i_start;
  logic       i_valid_result;
  logic [7:0] i_result;
  logic       i_carry;
  logic       i_zero_flag;
  logic       i_all_done;
  logic       o_rd_valid;
  logic       i_rd_ready;
  logic [9:0] o_rd_data;
  logic [3:0] o_count;
  logic       o_full;
  logic       o_empty;
  logic       o_overflow;
  logic [7:0] o_total;
  logic       o_done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];

  mest_pro_result_buf #(.DEPTH(8), .DATA_W(8)) dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_valid_result(i_valid_result),
    .i_result(i_result), .i_carry(i_carry), .i_zero_flag(i_zero_flag), .i_all_done(i_all_done),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data), .o_count(o_count),
    .o_full(o_full), .o_empty(o_empty), .o_overflow(o_overflow), .o_total(o_total), .o_done(o_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic start_run();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic c, input logic z, input bit kept);
    i_valid_result = 1'b1; i_result = d; i_carry = c; i_zero_flag = z;
    if (kept) exp_q.push_back({c, z, d});
    @(negedge clk);
    i_valid_result = 1'b0;
  endtask

  // Reads the expected queue out with ready held high; returns on the cycle after the last pop.
  task automatic drain_expect(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 64) begin
      n_cmp++;
      if (o_rd_valid !== 1'b1 || o_rd_data !== exp_q[0]) begin
        n_bad++;
        $display("FAIL %s_drain got valid=%b data=%h want valid=1 data=%h", name, o_rd_valid, o_rd_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      i_rd_ready = 1'b1;
      @(negedge clk);
      i_all_done = 1'b0;
      guard++;
    end
    i_rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({o_rd_valid, o_rd_data, o_count, o_full, o_empty, o_overflow, o_total, o_done} !==
        {1'b0, 10'h000, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs got valid=%b data=%h count=%0d full=%b empty=%b ovf=%b total=%0d done=%b",
               o_rd_valid, o_rd_data, o_count, o_full, o_empty, o_overflow, o_total, o_done);
    end
    i_reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_empty !== 1'b1 || o_done !== 1'b0) begin
      n_bad++; $display("FAIL reset_release got empty=%b done=%b want 1 0", o_empty, o_done);
    end
  endtask

  task automatic test_basic();
    start_run();
    push(8'h11, 1'b0, 1'b0, 1);
    push(8'h22, 1'b0, 1'b0, 1);
    push(8'hFF, 1'b1, 1'b0, 1);
    n_cmp++;
    if (o_count !== 4'd3 || o_rd_valid !== 1'b1 || o_rd_data !== 10'h011) begin
      n_bad++; $display("FAIL basic_hold got count=%0d valid=%b data=%h want 3 1 011", o_count, o_rd_valid, o_rd_data);
    end
    n_cmp++;
    if (o_total !== 8'd3 || o_done !== 1'b0) begin
      n_bad++; $display("FAIL basic_total got total=%0d done=%b want 3 0", o_total, o_done);
    end
    i_all_done = 1'b1;
    drain_expect("basic");
    n_cmp++;
    if (o_done !== 1'b1 || o_empty !== 1'b1 || o_total !== 8'd3) begin
      n_bad++; $display("FAIL basic_done got done=%b empty=%b total=%0d want 1 1 3", o_done, o_empty, o_total);
    end
    n_cmp++;
    if (o_rd_valid !== 1'b0 || o_rd_data !== 10'h2FF) begin
      n_bad++; $display("FAIL basic_hold_data got valid=%b data=%h want 0 2ff", o_rd_valid, o_rd_data);
    end
  endtask

  task automatic test_overflow_drop();
    start_run();
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i), 1'b0, 1'b0, 1);
    push(8'h38, 1'b0, 1'b0, 0);
    n_cmp++;
    if (o_full !== 1'b1 || o_count !== 4'd8 || o_overflow !== 1'b1 || o_total !== 8'd8) begin
      n_bad++; $display("FAIL ovf_drop got full=%b count=%0d ovf=%b total=%0d want 1 8 1 8", o_full, o_count, o_overflow, o_total);
    end
    i_all_done = 1'b1;
    drain_expect("ovf_drop");
    n_cmp++;
    if (o_done !== 1'b1 || o_overflow !== 1'b1 || o_empty !== 1'b1) begin
      n_bad++; $display("FAIL ovf_sticky got done=%b ovf=%b empty=%b want 1 1 1", o_done, o_overflow, o_empty);
    end
  endtask

  task automatic test_restart();
    start_run();
    n_cmp++;
    if (o_overflow !== 1'b0 || o_total !== 8'd0 || o_done !== 1'b0) begin
      n_bad++; $display("FAIL restart_clear got ovf=%b total=%0d done=%b want 0 0 0", o_overflow, o_total, o_done);
    end
    push(8'h00, 1'b0, 1'b1, 1);
    push(8'h7A, 1'b1, 1'b1, 1);
    n_cmp++;
    if (o_count !== 4'd2 || o_rd_data !== 10'h100) begin
      n_bad++; $display("FAIL restart_head got count=%0d data=%h want 2 100", o_count, o_rd_data);
    end
    i_all_done = 1'b1;
    drain_expect("restart");
    n_cmp++;
    if (o_done !== 1'b1 || o_total !== 8'd2) begin
      n_bad++; $display("FAIL restart_done got done=%b total=%0d want 1 2", o_done, o_total);
    end
  endtask

  task automatic test_overflow_accept();
    start_run();
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i), 1'b0, 1'b0, 1);
    n_cmp++;
    if (o_rd_data !== 10'h040) begin
      n_bad++; $display("FAIL accept_head got %h want 040", o_rd_data);
    end
    void'(exp_q.pop_front());
    i_rd_ready = 1'b1;
    push(8'h48, 1'b0, 1'b0, 1);
    i_rd_ready = 1'b0;
    n_cmp++;
    if (o_count !== 4'd8 || o_full !== 1'b1 || o_overflow !== 1'b0 || o_total !== 8'd9) begin
      n_bad++; $display("FAIL accept_full got count=%0d full=%b ovf=%b total=%0d want 8 1 0 9", o_count, o_full, o_overflow, o_total);
    end
    i_all_done = 1'b1;
    drain_expect("accept");
    n_cmp++;
    if (o_done !== 1'b1) begin
      n_bad++; $display("FAIL accept_done got %b want 1", o_done);
    end
  endtask

  task automatic test_back_to_back();
    start_run();
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        n_cmp++;
        if (o_rd_valid !== 1'b1 || o_rd_data !== {2'b00, 8'h50 + 8'(i - 1)} || o_count > 4'd1) begin
          n_bad++;
          $display("FAIL stream_%0d got valid=%b data=%h count=%0d want 1 %h <=1", i, o_rd_valid, o_rd_data, o_count, 8'h50 + 8'(i - 1));
        end
      end
      i_valid_result = 1'b1; i_result = 8'h50 + 8'(i); i_carry = 1'b0; i_zero_flag = 1'b0;
      i_rd_ready = 1'b1;
      @(negedge clk);
    end
    i_valid_result = 1'b0;
    n_cmp++;
    if (o_rd_data !== 10'h063 || o_count !== 4'd1) begin
      n_bad++; $display("FAIL stream_last got data=%h count=%0d want 063 1", o_rd_data, o_count);
    end
    i_all_done = 1'b1;
    @(negedge clk);
    i_all_done = 1'b0;
    @(negedge clk);
    i_rd_ready = 1'b0;
    n_cmp++;
    if (o_done !== 1'b1 || o_total !== 8'd20 || o_empty !== 1'b1) begin
      n_bad++; $display("FAIL stream_done got done=%b total=%0d empty=%b want 1 20 1", o_done, o_total, o_empty);
    end
  endtask

  task automatic test_zero_run();
    start_run();
    i_all_done = 1'b1;
    @(negedge clk);
    i_all_done = 1'b0;
    n_cmp++;
    if (o_done !== 1'b0 || o_rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL zero_run_early got done=%b valid=%b want 0 0", o_done, o_rd_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (o_done !== 1'b1 || o_rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL zero_run_done got done=%b valid=%b want 1 0", o_done, o_rd_valid);
    end
    push(8'hAA, 1'b1, 1'b1, 0);
    n_cmp++;
    if (o_count !== 4'd0 || o_total !== 8'd0 || o_overflow !== 1'b0 || o_rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL done_ignore got count=%0d total=%0d ovf=%b valid=%b want 0 0 0 0", o_count, o_total, o_overflow, o_rd_valid);
    end
  endtask

  task automatic test_reset_mid();
    start_run();
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1'b1, 1'b0, 1);
    n_cmp++;
    if (o_count !== 4'd5) begin
      n_bad++; $display("FAIL mid_count got %0d want 5", o_count);
    end
    #2 i_reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_rd_valid, o_rd_data, o_count, o_full, o_empty, o_overflow, o_total, o_done} !==
        {1'b0, 10'h000, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_reset got valid=%b data=%h count=%0d full=%b empty=%b ovf=%b total=%0d done=%b",
               o_rd_valid, o_rd_data, o_count, o_full, o_empty, o_overflow, o_total, o_done);
    end
    exp_q.delete();
    @(negedge clk);
    i_reset_n = 1'b1;
    @(negedge clk);
    push(8'h99, 1'b0, 1'b0, 0);
    n_cmp++;
    if (o_count !== 4'd0 || o_rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_idle_ignore got count=%0d valid=%b want 0 0", o_count, o_rd_valid);
    end
    start_run();
    push(8'h12, 1'b0, 1'b0, 1);
    n_cmp++;
    if (o_count !== 4'd1 || o_rd_data !== 10'h012) begin
      n_bad++; $display("FAIL mid_rerun got count=%0d data=%h want 1 012", o_count, o_rd_data);
    end
  endtask

  initial begin
    i_reset_n = 1'b0; i_start = 1'b0; i_valid_result = 1'b0; i_result = '0;
    i_carry = 1'b0; i_zero_flag = 1'b0; i_all_done = 1'b0; i_rd_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow_drop();
    test_restart();
    test_overflow_accept();
    test_back_to_back();
    test_zero_run();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
